data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Handshaked data-memory responder: the target side of the CPU's load/store port, serving one outstanding read or write at a time with a programmable wait-state latency. It replaces the zero-latency data memory when the core talks through a valid/ready request/response channel (multicycle or pipelined core, or a bus bridge). Storage is byte-addressable and little-endian. Supports word and byte (zero-extended) accesses, with error reporting for misaligned or out-of-range addresses.

## Interface
- DATA_WIDTH, 32, data and address width; fixed at 32.
- ADDR_WIDTH, 12, log2 of memory size in bytes (default 4 KiB).
- LATENCY, 2, wait-state cycles between acceptance and commit/response; legal range 0–15.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (ByteOp), 0 = word access.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; byte stores use bits [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  access rejected: misaligned word, or address ≥ 2^ADDR_WIDTH.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** req_ready = 1. On req_valid && req_ready, latch we/byte/addr/wdata.
  - LATENCY > 0: load counter with LATENCY-1 and go to WAIT.
  - LATENCY = 0: commit and go straight to RESP.
- **WAIT:** req_ready = 0. Decrement the counter each cycle; when it reaches 0, commit and go to RESP on that edge.
- **Commit:**
  - Compute err = (!byte && addr[1:0] != 0) || (addr[31:ADDR_WIDTH] != 0).
  - If !err and we, write the memory: a word store writes 4 bytes little-endian at addr; a byte store writes wdata[7:0] at addr.
  - If !err and !we, register rdata: a word load gives {m[a+3], m[a+2], m[a+1], m[a]}; a byte load gives {24'b0, m[a]}.
  - On err: no memory change, rdata = 0.
  - Register rsp_err and rsp_rdata.
- **RESP:** rsp_valid = 1, req_ready = 0. rsp_rdata and rsp_err hold stable until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid/rsp_rdata/rsp_err and go to IDLE.
- Request inputs are ignored outside IDLE. The requester must hold req_valid and its fields until accepted.
- Memory contents are not reset; initial contents are X (benches preload through a hierarchical task).

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0.
- Acceptance edge = E0. rsp_valid rises in the cycle after edge E0+LATENCY, giving LATENCY+1 cycles of request-to-response latency.
- A store is visible to any later load, because commit precedes the response.
- req_ready returns to 1 in the cycle after the response handshake edge. Peak throughput is one access per LATENCY+2 cycles.
- Response backpressure (rsp_ready = 0) stalls in RESP indefinitely with no output change.
- req_valid asserted during RESP is not accepted in that cycle, even when rsp_ready = 1 in the same cycle.
- Reset asserted mid-transaction:
  - In WAIT: the pending store is dropped and memory is unchanged.
  - In RESP: the committed store is kept; the response is lost.
  - All outputs go to their reset values asynchronously.
- Address 2^ADDR_WIDTH-1 with a byte access is legal; a word access at 2^ADDR_WIDTH-4 is legal (highest word).

## Structure
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - CNT_WIDTH = 4;
  - function is_err(addr, byte) shared with the bench model.
- Sub-module dmem_array: byte-wide storage of 2^ADDR_WIDTH bytes.
  - Synchronous write with 4-bit byte enable.
  - Combinational 32-bit little-endian read of the word at the given byte address.
- Top holds the FSM, latch registers, counter, error check and output registers.

## Test plan
- Reset, then word store addr 0x10, data 0xDEADBEEF; load word 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid 3 cycles after acceptance (LATENCY=2).
- After that store, byte store 0xA5 to 0x11; word load 0x10 → 0xDEADA5EF; byte load 0x13 → 0x000000DE.
- Word load 0x12 (misaligned) → rsp_err 1, rdata 0. Word store 0x1000 (out of range, ADDR_WIDTH=12) → rsp_err 1; reading 0x000 shows it unchanged.
- Hold rsp_ready 0 for 5 cycles in RESP → rsp_valid/rdata stable and req_ready 0 throughout. Raise rsp_ready → req_ready 1 in the next cycle.
- Store 0x12345678 to 0x20, assert rst in WAIT → all outputs reset; load 0x20 returns its prior (preloaded 0) value.
- LATENCY=0 build: back-to-back requests with rsp_ready tied 1 → one response every 2 cycles, rsp_valid in the cycle after each acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the handshaked data-memory responder.
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   CNT_WIDTH : width of the wait-state counter (latencies 0..15)
//   is_err    : access legality check (misaligned word / out-of-range address)
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // An access is rejected when a word access is not 4-byte aligned, or when
    // any address bit above the implemented memory size is set.
    function automatic logic is_err(input logic [31:0] addr,
                                    input logic        byteOp,
                                    input int unsigned addrWidth);
        logic misaligned;
        logic outOfRange;
        misaligned = !byteOp && (addr[1:0] != 2'b00);
        outOfRange = (addr >> addrWidth) != 32'd0;
        return misaligned || outOfRange;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Byte-wide storage of 2^ADDR_WIDTH bytes, little-endian word view.
// Ports:
//   clk_i    : clock, writes happen on the rising edge
//   addr_i   : byte address of the word (lane 0 = addr_i, lane k = addr_i+k)
//   we_i     : write enable
//   be_i     : per-lane byte enable
//   wdata_i  : write data, lane k takes bits [8k+7:8k]
//   rdata_o  : combinational read {m[a+3], m[a+2], m[a+1], m[a]}
// Contents are deliberately not reset.
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem      [DEPTH];
    logic [ADDR_WIDTH-1:0] laneAddr [4];

    // Byte address of each of the four lanes; wraps inside the array so a
    // byte access at the top address never indexes past the end.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            laneAddr[k] = addr_i + ADDR_WIDTH'(k);
        end
    end

    assign rdata_o = {mem[laneAddr[3]], mem[laneAddr[2]],
                      mem[laneAddr[1]], mem[laneAddr[0]]};

    // Lane-wise synchronous write; only enabled lanes change.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[laneAddr[k]] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Target side of a load/store port: accepts one request at a time over a
// valid/ready channel, waits LATENCY cycles, commits to memory and presents a
// registered response held until the requester takes it.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o : request handshake
//   req_we_i                : 1 = store, 0 = load
//   req_byte_i              : 1 = byte access, 0 = word access
//   req_addr_i, req_wdata_i : byte address, store data
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_rdata_o             : load data (0 for stores and errors)
//   rsp_err_o               : misaligned word or out-of-range address
// ----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic                  req_byte_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        (LATENCY > 0) ? CNT_WIDTH'(LATENCY - 1) : '0;
    localparam logic LATENCY_ZERO = (LATENCY == 0);

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  we_q;
    logic                  byte_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  reqReady_q;
    logic                  rspValid_q;
    logic [31:0]           rspRdata_q;
    logic                  rspErr_q;

    logic                  commitWe_d;
    logic                  commitByte_d;
    logic [31:0]           commitAddr_d;
    logic [31:0]           commitWdata_d;
    logic                  commitFire_d;
    logic                  commitErr_d;
    logic [31:0]           commitRdata_d;
    logic                  memWe;
    logic [3:0]            memBe;
    logic [31:0]           arrayRdata;

    // Commit operand selection. With zero latency the commit happens on the
    // acceptance edge itself, so the live request fields are used instead of
    // the latched copies.
    always_comb begin
        if (state_q == IDLE) begin
            commitWe_d    = req_we_i;
            commitByte_d  = req_byte_i;
            commitAddr_d  = req_addr_i;
            commitWdata_d = req_wdata_i;
        end else begin
            commitWe_d    = we_q;
            commitByte_d  = byte_q;
            commitAddr_d  = addr_q;
            commitWdata_d = wdata_q;
        end
        commitFire_d = ((state_q == IDLE) && req_valid_i && LATENCY_ZERO) ||
                       ((state_q == WAIT) && (cnt_q == '0));
        commitErr_d  = is_err(commitAddr_d, commitByte_d, ADDR_WIDTH);
        memWe        = commitFire_d && commitWe_d && !commitErr_d;
        memBe        = commitByte_d ? 4'b0001 : 4'b1111;
        if (commitErr_d || commitWe_d) begin
            commitRdata_d = '0;
        end else if (commitByte_d) begin
            commitRdata_d = {24'b0, arrayRdata[7:0]};
        end else begin
            commitRdata_d = arrayRdata;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .addr_i  (commitAddr_d[ADDR_WIDTH-1:0]),
        .we_i    (memWe),
        .be_i    (memBe),
        .wdata_i (commitWdata_d),
        .rdata_o (arrayRdata)
    );

    // Responder FSM: accept in IDLE, count wait states in WAIT, hold the
    // registered response in RESP until the requester takes it. All outputs
    // are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        byte_q     <= req_byte_i;
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        reqReady_q <= 1'b0;
                        if (LATENCY_ZERO) begin
                            rspRdata_q <= commitRdata_d;
                            rspErr_q   <= commitErr_d;
                            rspValid_q <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rspRdata_q <= commitRdata_d;
                        rspErr_q   <= commitErr_d;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rspValid_q <= 1'b0;
                        rspRdata_q <= '0;
                        rspErr_q   <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = reqReady_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Exercises a LATENCY=2 responder with directed vectors, stall/reset
// sequences and random accesses against a byte-array memory model, plus a
// LATENCY=0 responder driven back-to-back.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        reqValid, reqWe, reqByte, rspReady;
    logic        reqReady, rspValid, rspErr;
    logic [31:0] reqAddr, reqWdata, rspRdata;

    logic        reqValid0, reqWe0, reqByte0, rspReady0;
    logic        reqReady0, rspValid0, rspErr0;
    logic [31:0] reqAddr0, reqWdata0, rspRdata0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] modelMem [0:4095];

    typedef struct {
        logic        we;
        logic        byteOp;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        string       name;
    } vector_t;

    vector_t vectors  [$];
    vector_t vectors0 [$];

    data_mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .LATENCY    (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_we_i    (reqWe),
        .req_byte_i  (reqByte),
        .req_addr_i  (reqAddr),
        .req_wdata_i (reqWdata),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_rdata_o (rspRdata),
        .rsp_err_o   (rspErr)
    );

    data_mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .LATENCY    (0)
    ) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid0),
        .req_ready_o (reqReady0),
        .req_we_i    (reqWe0),
        .req_byte_i  (reqByte0),
        .req_addr_i  (reqAddr0),
        .req_wdata_i (reqWdata0),
        .rsp_valid_o (rspValid0),
        .rsp_ready_i (rspReady0),
        .rsp_rdata_o (rspRdata0),
        .rsp_err_o   (rspErr0)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference behaviour: a flat byte array, little-endian words, errors for
    // unaligned words or addresses at or beyond 4 KiB.
    task automatic modelAccess(input logic we, input logic byteOp,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] expRdata, output logic expErr);
        longint a;
        a        = longint'(addr);
        expErr   = (a >= 4096) || (!byteOp && (a % 4 != 0));
        expRdata = 32'h0;
        if (!expErr) begin
            if (we) begin
                if (byteOp) begin
                    modelMem[a] = wdata[7:0];
                end else begin
                    for (int k = 0; k < 4; k++) modelMem[a + k] = wdata[8*k +: 8];
                end
            end else if (byteOp) begin
                expRdata = {24'h0, modelMem[a]};
            end else begin
                expRdata = {modelMem[a + 3], modelMem[a + 2], modelMem[a + 1], modelMem[a]};
            end
        end
    endtask

    // One complete transaction on the LATENCY=2 responder with rsp_ready
    // held high; reports data, error and cycles from acceptance edge to valid.
    task automatic applyStimulus(input logic we, input logic byteOp,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output int cycles);
        reqValid = 1'b1;
        reqWe    = we;
        reqByte  = byteOp;
        reqAddr  = addr;
        reqWdata = wdata;
        rspReady = 1'b1;
        tick();
        reqValid = 1'b0;
        cycles   = 1;
        while (!rspValid && cycles < 40) begin
            tick();
            cycles++;
        end
        rdata = rspRdata;
        err   = rspErr;
        if (!rspValid) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL timeout: no response for addr 0x%08h, required rsp_valid 1", addr);
        end
        tick();
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        logic [31:0] expRdata;
        logic        expErr;
        logic [31:0] rAddr;

        for (int i = 0; i < 4096; i++) modelMem[i] = 8'h00;

        rst       = 1'b1;
        reqValid  = 1'b0; reqWe  = 1'b0; reqByte  = 1'b0; reqAddr  = '0; reqWdata  = '0; rspReady  = 1'b0;
        reqValid0 = 1'b0; reqWe0 = 1'b0; reqByte0 = 1'b0; reqAddr0 = '0; reqWdata0 = '0; rspReady0 = 1'b1;

        // Reset state of both instances
        #2;
        checkOutput("reset_req_ready", reqReady, 1);
        checkOutput("reset_rsp_valid", rspValid, 0);
        checkOutput("reset_rsp_rdata", rspRdata, 0);
        checkOutput("reset_rsp_err", rspErr, 0);
        checkOutput("reset0_req_ready", reqReady0, 1);
        checkOutput("reset0_rsp_valid", rspValid0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Zero the two regions the rest of the test touches
        for (int a = 0; a < 64; a += 4) begin
            applyStimulus(1'b1, 1'b0, 32'(a), 32'h0, rdata, err, cycles);
            applyStimulus(1'b1, 1'b0, 32'(4032 + a), 32'h0, rdata, err, cycles);
        end

        // Directed vectors: we, byte, addr, wdata, expected rdata, expected err
        vectors.push_back('{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, "st_word_10"});
        vectors.push_back('{1'b0, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, "ld_word_10"});
        vectors.push_back('{1'b1, 1'b1, 32'h011, 32'h000000A5, 32'h0, 1'b0, "st_byte_11"});
        vectors.push_back('{1'b0, 1'b0, 32'h010, 32'h0, 32'hDEADA5EF, 1'b0, "ld_word_10b"});
        vectors.push_back('{1'b0, 1'b1, 32'h013, 32'h0, 32'h000000DE, 1'b0, "ld_byte_13"});
        vectors.push_back('{1'b0, 1'b0, 32'h012, 32'h0, 32'h0, 1'b1, "ld_word_misal"});
        vectors.push_back('{1'b1, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, "st_word_oor"});
        vectors.push_back('{1'b0, 1'b0, 32'h000, 32'h0, 32'h0, 1'b0, "ld_word_000"});
        vectors.push_back('{1'b1, 1'b1, 32'hFFF, 32'h00000077, 32'h0, 1'b0, "st_byte_fff"});
        vectors.push_back('{1'b0, 1'b1, 32'hFFF, 32'h0, 32'h00000077, 1'b0, "ld_byte_fff"});
        vectors.push_back('{1'b1, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, "st_word_ffc"});
        vectors.push_back('{1'b0, 1'b1, 32'hFFE, 32'h0, 32'h000000FE, 1'b0, "ld_byte_ffe"});
        vectors.push_back('{1'b1, 1'b0, 32'hFFD, 32'h12345678, 32'h0, 1'b1, "st_word_misal"});
        vectors.push_back('{1'b0, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, "ld_word_ffc"});
        vectors.push_back('{1'b0, 1'b1, 32'h1000, 32'h0, 32'h0, 1'b1, "ld_byte_oor"});
        vectors.push_back('{1'b0, 1'b1, 32'h80000010, 32'h0, 32'h0, 1'b1, "ld_byte_high"});

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].we, vectors[i].byteOp, vectors[i].addr,
                          vectors[i].wdata, rdata, err, cycles);
            modelAccess(vectors[i].we, vectors[i].byteOp, vectors[i].addr,
                        vectors[i].wdata, expRdata, expErr);
            checkOutput({vectors[i].name, "_rdata"}, rdata, vectors[i].expRdata);
            checkOutput({vectors[i].name, "_err"}, err, vectors[i].expErr);
            checkOutput({vectors[i].name, "_latency"}, cycles, 3);
        end

        // Response backpressure; a new request held during RESP must wait
        reqValid = 1'b1; reqWe = 1'b0; reqByte = 1'b0; reqAddr = 32'h010; rspReady = 1'b0;
        tick();
        reqValid = 1'b0;
        cycles   = 0;
        while (!rspValid && cycles < 40) begin
            tick();
            cycles++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rsp_valid", rspValid, 1);
            checkOutput("stall_rsp_rdata", rspRdata, 32'hDEADA5EF);
            checkOutput("stall_req_ready", reqReady, 0);
            if (i == 2) begin
                reqValid = 1'b1; reqWe = 1'b1; reqByte = 1'b0;
                reqAddr  = 32'h030; reqWdata = 32'h0BADF00D;
            end
            tick();
        end
        rspReady = 1'b1;
        tick();
        checkOutput("release_rsp_valid", rspValid, 0);
        checkOutput("release_rsp_rdata", rspRdata, 0);
        checkOutput("release_req_ready", reqReady, 1);
        tick();
        reqValid = 1'b0;
        checkOutput("held_req_accepted", reqReady, 0);
        cycles = 0;
        while (!rspValid && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("held_store_err", rspErr, 0);
        tick();
        modelAccess(1'b1, 1'b0, 32'h030, 32'h0BADF00D, expRdata, expErr);
        applyStimulus(1'b0, 1'b0, 32'h030, 32'h0, rdata, err, cycles);
        checkOutput("held_store_readback", rdata, 32'h0BADF00D);

        // Reset during WAIT drops the pending store
        reqValid = 1'b1; reqWe = 1'b1; reqByte = 1'b0; reqAddr = 32'h020; reqWdata = 32'h12345678;
        tick();
        reqValid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_wait_req_ready", reqReady, 1);
        checkOutput("rst_wait_rsp_valid", rspValid, 0);
        checkOutput("rst_wait_rsp_rdata", rspRdata, 0);
        checkOutput("rst_wait_rsp_err", rspErr, 0);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h020, 32'h0, rdata, err, cycles);
        checkOutput("rst_wait_mem_kept", rdata, 32'h0);

        // Reset during RESP keeps the committed store
        reqValid = 1'b1; reqWe = 1'b1; reqByte = 1'b0; reqAddr = 32'h024; reqWdata = 32'hAABBCCDD;
        rspReady = 1'b0;
        tick();
        reqValid = 1'b0;
        cycles   = 0;
        while (!rspValid && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("rst_resp_reached", rspValid, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_resp_rsp_valid", rspValid, 0);
        checkOutput("rst_resp_req_ready", reqReady, 1);
        tick();
        rst = 1'b0;
        tick();
        modelAccess(1'b1, 1'b0, 32'h024, 32'hAABBCCDD, expRdata, expErr);
        applyStimulus(1'b0, 1'b0, 32'h024, 32'h0, rdata, err, cycles);
        checkOutput("rst_resp_store_kept", rdata, 32'hAABBCCDD);

        // Random accesses against the model
        for (int n = 0; n < 150; n++) begin
            logic rWe, rByte;
            logic [31:0] rData;
            rWe   = 1'($urandom_range(0, 1));
            rByte = 1'($urandom_range(0, 1));
            rData = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    rAddr = 32'($urandom_range(0, 63));
                2, 3:    rAddr = 32'(4032 + $urandom_range(0, 63));
                default: rAddr = 32'h1000 + 32'($urandom_range(0, 4095)) * 32'($urandom_range(1, 3));
            endcase
            if (!rByte && $urandom_range(0, 3) != 0) rAddr = rAddr & ~32'h3;
            applyStimulus(rWe, rByte, rAddr, rData, rdata, err, cycles);
            modelAccess(rWe, rByte, rAddr, rData, expRdata, expErr);
            checkOutput("rand_rdata", rdata, expRdata);
            checkOutput("rand_err", err, expErr);
        end

        // Zero-latency instance, back-to-back with rsp_ready tied high
        vectors0.push_back('{1'b1, 1'b0, 32'h008, 32'h11223344, 32'h0, 1'b0, "l0_st_word_8"});
        vectors0.push_back('{1'b0, 1'b0, 32'h008, 32'h0, 32'h11223344, 1'b0, "l0_ld_word_8"});
        vectors0.push_back('{1'b1, 1'b1, 32'h009, 32'h00000055, 32'h0, 1'b0, "l0_st_byte_9"});
        vectors0.push_back('{1'b0, 1'b0, 32'h008, 32'h0, 32'h11225544, 1'b0, "l0_ld_word_8b"});
        vectors0.push_back('{1'b0, 1'b1, 32'h00B, 32'h0, 32'h00000011, 1'b0, "l0_ld_byte_b"});
        vectors0.push_back('{1'b0, 1'b0, 32'h006, 32'h0, 32'h0, 1'b1, "l0_ld_misal"});

        reqValid0 = 1'b1;
        foreach (vectors0[i]) begin
            reqWe0    = vectors0[i].we;
            reqByte0  = vectors0[i].byteOp;
            reqAddr0  = vectors0[i].addr;
            reqWdata0 = vectors0[i].wdata;
            tick();
            checkOutput({vectors0[i].name, "_valid"}, rspValid0, 1);
            checkOutput({vectors0[i].name, "_rdata"}, rspRdata0, vectors0[i].expRdata);
            checkOutput({vectors0[i].name, "_err"}, rspErr0, vectors0[i].expErr);
            tick();
            checkOutput({vectors0[i].name, "_idle_valid"}, rspValid0, 0);
            checkOutput({vectors0[i].name, "_idle_ready"}, reqReady0, 1);
        end
        reqValid0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
